mem_port_arbiter: RTL and testbench

//   Shares one single-port synchronous 256x32 memory between the instruction-fetch port (read-only)
//   and the data port (read/write), using a clocked request/grant handshake.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_arb_resp_pipe.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths and encodings for the fetch/data memory port arbiter.
// No logic; constants and types only.
// Imported by the arbiter top and its response pipe.
package mem_port_arbiter_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 32;

    // Owner tag carried alongside each memory read while it is in flight
    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_INSTR = 2'd1,
        TAG_DATA  = 2'd2
    } tag_e;

    // Identity of the last winner, used by the round-robin build
    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

endpackage

// File: rtl/mem_arb_resp_pipe.sv
// Purpose: tracks read ownership for READ_LATENCY cycles, then demuxes mem_read_val to its owner.
// Latency: tag leaves the pipe with the memory data; response registered one cycle later.
// Backpressure: none; full throughput, every pushed tag is delivered unless reset intervenes.
module mem_arb_resp_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  tag_e                  push_tag,
    input  logic [MEM_DATA_W-1:0] mem_read_val,
    output logic                  instr_rvalid,
    output logic [MEM_DATA_W-1:0] instr_rdata,
    output logic                  data_rvalid,
    output logic [MEM_DATA_W-1:0] data_rdata
);

    tag_e tag_pipe [READ_LATENCY];
    tag_e tag_out;

    assign tag_out = tag_pipe[READ_LATENCY-1];

    // Shift the owner tag in lockstep with the memory read latency; reset drops in-flight reads
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) tag_pipe[i] <= TAG_NONE;
        end else begin
            tag_pipe[0] <= push_tag;
            for (int i = 1; i < READ_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    // Register memory data into the owning port; the other port reads back zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_rvalid <= 1'b0;
            instr_rdata  <= '0;
            data_rvalid  <= 1'b0;
            data_rdata   <= '0;
        end else begin
            instr_rvalid <= (tag_out == TAG_INSTR);
            instr_rdata  <= (tag_out == TAG_INSTR) ? mem_read_val : '0;
            data_rvalid  <= (tag_out == TAG_DATA);
            data_rdata   <= (tag_out == TAG_DATA) ? mem_read_val : '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port memory between fetch (read-only) and data (read/write) ports.
// Latency: grant combinational; read data READ_LATENCY+1 cycles after grant. Build option MEM_ARB_ROUND_ROBIN_EN.
// Backpressure: requester holds req until gnt; a refused port is forced through after MAX_WAIT refusals.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int MAX_WAIT     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_req,
    input  logic [MEM_ADDR_W-1:0] instr_addr,
    output logic                  instr_gnt,
    output logic                  instr_rvalid,
    output logic [MEM_DATA_W-1:0] instr_rdata,
    input  logic                  data_req,
    input  logic                  data_we,
    input  logic [MEM_ADDR_W-1:0] data_addr,
    input  logic [MEM_DATA_W-1:0] data_wdata,
    output logic                  data_gnt,
    output logic                  data_rvalid,
    output logic [MEM_DATA_W-1:0] data_rdata,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic                  mem_read_en,
    output logic                  mem_write_en,
    output logic [MEM_DATA_W-1:0] mem_write_val,
    input  logic [MEM_DATA_W-1:0] mem_read_val
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0] instr_wait;
    logic [3:0] data_wait;
    logic       force_instr;
    logic       force_data;
    logic       pick_data;
    tag_e       push_tag;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    port_e rr_last;
`endif

    // Pick a winner: starvation overrides first (data wins a tie), then the contention rule
    always_comb begin
        force_data  = data_req  && (data_wait  >= MAX_WAIT_C);
        force_instr = instr_req && (instr_wait >= MAX_WAIT_C);
        if (force_data) begin
            pick_data = 1'b1;
        end else if (force_instr) begin
            pick_data = 1'b0;
        end else if (data_req && instr_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            pick_data = (rr_last == PORT_INSTR);
`else
            pick_data = 1'b1;
`endif
        end else begin
            pick_data = data_req;
        end
        data_gnt  = rst_n && data_req && pick_data;
        instr_gnt = rst_n && instr_req && !pick_data;
    end

    // Steer the memory port to the granted requester; idle port parks at address 0
    always_comb begin
        mem_addr     = '0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        push_tag     = TAG_NONE;
        if (data_gnt) begin
            mem_addr     = data_addr;
            mem_read_en  = !data_we;
            mem_write_en = data_we;
            push_tag     = data_we ? TAG_NONE : TAG_DATA;
        end else if (instr_gnt) begin
            mem_addr    = instr_addr;
            mem_read_en = 1'b1;
            push_tag    = TAG_INSTR;
        end
    end

    assign mem_write_val = data_wdata;

    // Count consecutive refusals per port; saturate so the counter never wraps back to zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_wait <= '0;
            data_wait  <= '0;
        end else begin
            if (!instr_req || instr_gnt) instr_wait <= '0;
            else if (instr_wait != 4'hF) instr_wait <= instr_wait + 4'd1;
            if (!data_req || data_gnt) data_wait <= '0;
            else if (data_wait != 4'hF) data_wait <= data_wait + 4'd1;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remember the last winner so contention alternates between ports
    always_ff @(posedge clk) begin
        if (!rst_n) rr_last <= PORT_INSTR;
        else if (data_gnt) rr_last <= PORT_DATA;
        else if (instr_gnt) rr_last <= PORT_INSTR;
    end
`endif

    mem_arb_resp_pipe #(
        .READ_LATENCY(READ_LATENCY)
    ) u_resp_pipe (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_tag     (push_tag),
        .mem_read_val (mem_read_val),
        .instr_rvalid (instr_rvalid),
        .instr_rdata  (instr_rdata),
        .data_rvalid  (data_rvalid),
        .data_rdata   (data_rdata)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory, scoreboard of expected read responses.
// Expected read data and arrival cycle are queued when a read is granted and checked on arrival.
// Directed sequences cover reset, contention/starvation, lone fetch, write-then-read, mid-pipe reset.
module tb_mem_port_arbiter;

    localparam int RL = 1;
    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_req = 1'b0;
    logic [7:0]  instr_addr = '0;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [7:0]  data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic [7:0]  mem_addr;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_write_val;
    logic [31:0] mem_read_val;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.READ_LATENCY(RL), .MAX_WAIT(MW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_req     (instr_req),
        .instr_addr    (instr_addr),
        .instr_gnt     (instr_gnt),
        .instr_rvalid  (instr_rvalid),
        .instr_rdata   (instr_rdata),
        .data_req      (data_req),
        .data_we       (data_we),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_gnt      (data_gnt),
        .data_rvalid   (data_rvalid),
        .data_rdata    (data_rdata),
        .mem_addr      (mem_addr),
        .mem_read_en   (mem_read_en),
        .mem_write_en  (mem_write_en),
        .mem_write_val (mem_write_val),
        .mem_read_val  (mem_read_val)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Behavioural single-port memory with READ_LATENCY read pipeline
    logic [31:0] mem [256];
    logic [31:0] rd_q [RL];
    logic        mem_init = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_init) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= (i == 16) ? 32'hDEADBEEF : {16'hC0DE, 8'(i), 8'(i * 3)};
            mem_init <= 1'b1;
        end else if (mem_write_en) begin
            mem[mem_addr] <= mem_write_val;
        end
        if (mem_read_en) rd_q[0] <= mem[mem_addr];
        for (int i = 1; i < RL; i++) rd_q[i] <= rd_q[i-1];
    end

    assign mem_read_val = rd_q[RL-1];

    // Scoreboard and per-cycle invariants
    typedef struct {
        logic [31:0] dat;
        int          due;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];
    int   iw_b = 0;
    int   dw_b = 0;

    always @(negedge clk) begin
        if (iq.size() > 0 && iq[0].due == cyc) begin
            check_eq("instr_rvalid", instr_rvalid, 1);
            check_eq("instr_rdata", instr_rdata, iq[0].dat);
            void'(iq.pop_front());
        end else begin
            check_eq("instr_idle_rvalid", instr_rvalid, 0);
            check_eq("instr_idle_rdata", instr_rdata, 0);
        end
        if (dq.size() > 0 && dq[0].due == cyc) begin
            check_eq("data_rvalid", data_rvalid, 1);
            check_eq("data_rdata", data_rdata, dq[0].dat);
            void'(dq.pop_front());
        end else begin
            check_eq("data_idle_rvalid", data_rvalid, 0);
            check_eq("data_idle_rdata", data_rdata, 0);
        end
        if (!rst_n) begin
            iq.delete();
            dq.delete();
            iw_b = 0;
            dw_b = 0;
        end else begin
            check_eq("gnt_onehot", instr_gnt & data_gnt, 0);
            check_eq("instr_gnt_needs_req", instr_gnt & !instr_req, 0);
            check_eq("data_gnt_needs_req", data_gnt & !data_req, 0);
            if (instr_req && !instr_gnt) begin
                check_eq("instr_wait_bound", iw_b < MW, 1);
                iw_b++;
            end else iw_b = 0;
            if (data_req && !data_gnt) begin
                check_eq("data_wait_bound", dw_b < MW, 1);
                dw_b++;
            end else dw_b = 0;
            if (instr_gnt) iq.push_back('{dat: mem[instr_addr], due: cyc + RL + 1});
            if (data_gnt && !data_we) dq.push_back('{dat: mem[data_addr], due: cyc + RL + 1});
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    logic ig, dg, exp_d;

    initial begin
        // Reset with both requests pending
        instr_req = 1'b1; instr_addr = 8'h01;
        data_req  = 1'b1; data_addr  = 8'h02; data_we = 1'b0;
        repeat (3) drive_edge();
        @(negedge clk);
        check_eq("rst_instr_gnt", instr_gnt, 0);
        check_eq("rst_data_gnt", data_gnt, 0);
        check_eq("rst_read_en", mem_read_en, 0);
        check_eq("rst_write_en", mem_write_en, 0);
        check_eq("rst_mem_addr", mem_addr, 0);

        // Release reset with both held: contention and starvation pattern
        drive_edge();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_d = ((k % 2) == 0);
`else
            exp_d = ((k % 5) != 4);
`endif
            check_eq("contend_data_gnt", data_gnt, exp_d);
            check_eq("contend_instr_gnt", instr_gnt, !exp_d);
            check_eq("contend_mem_addr", mem_addr, exp_d ? 32'h02 : 32'h01);
            check_eq("contend_read_en", mem_read_en, 1);
        end
        drive_edge();
        instr_req = 1'b0; data_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_eq("idle_mem_addr", mem_addr, 0);
            check_eq("idle_strobes", {mem_read_en, mem_write_en}, 0);
        end

        // Lone fetch from 0x10
        drive_edge();
        instr_req = 1'b1; instr_addr = 8'h10;
        @(negedge clk);
        check_eq("fetch_gnt", instr_gnt, 1);
        check_eq("fetch_mem_addr", mem_addr, 32'h10);
        drive_edge();
        instr_req = 1'b0;
        @(negedge clk);
        check_eq("fetch_rvalid_early", instr_rvalid, 0);
        @(negedge clk);
        check_eq("fetch_rvalid", instr_rvalid, 1);
        check_eq("fetch_rdata", instr_rdata, 32'hDEADBEEF);

        // Data write then read-back of the same word
        drive_edge();
        data_req = 1'b1; data_we = 1'b1; data_addr = 8'h20; data_wdata = 32'h55AA55AA;
        @(negedge clk);
        check_eq("wr_gnt", data_gnt, 1);
        check_eq("wr_strobes", {mem_read_en, mem_write_en}, 2'b01);
        check_eq("wr_mem_addr", mem_addr, 32'h20);
        check_eq("wr_mem_val", mem_write_val, 32'h55AA55AA);
        drive_edge();
        data_we = 1'b0; data_wdata = 32'h0;
        @(negedge clk);
        check_eq("rd_gnt", data_gnt, 1);
        check_eq("rd_strobes", {mem_read_en, mem_write_en}, 2'b10);
        drive_edge();
        data_req = 1'b0;
        @(negedge clk);
        check_eq("wr_no_rvalid", data_rvalid, 0);
        @(negedge clk);
        check_eq("rd_rvalid", data_rvalid, 1);
        check_eq("rd_rdata", data_rdata, 32'h55AA55AA);

        // Random traffic, requests held until granted
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            ig = instr_gnt;
            dg = data_gnt;
            drive_edge();
            if (!instr_req || ig) begin
                instr_req  = 1'($urandom_range(0, 1));
                instr_addr = 8'($urandom);
            end
            if (!data_req || dg) begin
                data_req   = 1'($urandom_range(0, 1));
                data_we    = ($urandom_range(0, 3) == 0);
                data_addr  = 8'($urandom);
                data_wdata = $urandom;
            end
        end
        drive_edge();
        instr_req = 1'b0; data_req = 1'b0;
        repeat (4) @(negedge clk);

        // Three reads back to back, then a one-cycle reset while they are in flight
        drive_edge();
        instr_req = 1'b1; instr_addr = 8'h30;
        drive_edge();
        instr_req = 1'b0; data_req = 1'b1; data_we = 1'b0; data_addr = 8'h31;
        drive_edge();
        data_req = 1'b0; instr_req = 1'b1; instr_addr = 8'h32;
        drive_edge();
        instr_req = 1'b0;
        rst_n = 1'b0;
        drive_edge();
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("sb_drained", iq.size() + dq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
